// File: rtl/request_encoder_32_5_pkg.sv
// Shared constants and state encoding for the 32-to-5 round-robin request encoder.
package request_encoder_32_5_pkg;

  localparam int unsigned INPUTS = 32;
  localparam int unsigned ADDR   = 5;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

endpackage

// File: rtl/priority_encoder_32_5.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit plus an any-set flag.
module priority_encoder_32_5
  import request_encoder_32_5_pkg::*;
(
  input  logic [INPUTS-1:0] i_vec,
  output logic [ADDR-1:0]   o_idx,
  output logic              o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_vec;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = INPUTS - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = i[ADDR-1:0];
      end
    end
  end

endmodule

// File: rtl/request_encoder_32_5.sv
// Collects one-hot request pulses as pending and grants them one at a time, round-robin,
// as an encoded address with a valid/ack handshake.
module request_encoder_32_5
  import request_encoder_32_5_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [INPUTS-1:0] i_req,
  input  logic              i_ack,
  output logic [ADDR-1:0]   o_addr,
  output logic              o_valid,
  output logic [INPUTS-1:0] o_pending
);

  state_e            r_state, w_state_d;
  logic [ADDR-1:0]   r_addr, w_addr_d;
  logic              r_valid, w_valid_d;
  logic [INPUTS-1:0] r_pending, w_pending_d;
  logic [ADDR-1:0]   r_ptr, w_ptr_d;

  logic [INPUTS-1:0] w_masked;
  logic [INPUTS-1:0] w_clr;
  logic [ADDR-1:0]   w_idx_masked, w_idx_all, w_sel;
  logic              w_any_masked, w_any_all;

  // Masked search covers indices at or above the pointer; the unmasked one is the wrap-around.
  assign w_masked = r_pending & ({INPUTS{1'b1}} << r_ptr);

  priority_encoder_32_5 u_pe_masked (
    .i_vec (w_masked),
    .o_idx (w_idx_masked),
    .o_any (w_any_masked)
  );

  priority_encoder_32_5 u_pe_all (
    .i_vec (r_pending),
    .o_idx (w_idx_all),
    .o_any (w_any_all)
  );

  assign w_sel = w_any_masked ? w_idx_masked : w_idx_all;

  always_comb begin
    w_clr       = '0;
    if (r_valid && i_ack) begin
      w_clr = INPUTS'(1) << r_addr;
    end
    // A request on the acked line in the same cycle survives.
    w_pending_d = (r_pending & ~w_clr) | i_req;
  end

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_valid_d = r_valid;
    w_ptr_d   = r_ptr;
    unique case (r_state)
      StIdle: begin
        w_valid_d = 1'b0;
        if (w_any_all) begin
          w_addr_d  = w_sel;
          w_valid_d = 1'b1;
          w_state_d = StGrant;
        end
      end
      StGrant: begin
        if (i_ack) begin
          w_valid_d = 1'b0;
          w_ptr_d   = r_addr + ADDR'(1);
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_addr    <= '0;
      r_valid   <= 1'b0;
      r_pending <= '0;
      r_ptr     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_addr    <= w_addr_d;
      r_valid   <= w_valid_d;
      r_pending <= w_pending_d;
      r_ptr     <= w_ptr_d;
    end
  end

  assign o_addr    = r_addr;
  assign o_valid   = r_valid;
  assign o_pending = r_pending;

endmodule

// File: tb/tb_request_encoder_32_5.sv
// Directed plus randomized bench for request_encoder_32_5 against a cycle-level reference model.
module tb_request_encoder_32_5;

  logic        clk;
  logic        rst_n;
  logic [31:0] req;
  logic        ack;
  logic [4:0]  addr;
  logic        valid;
  logic [31:0] pending;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pend;
  logic        m_valid;
  int          m_addr;
  int          m_ptr;

  request_encoder_32_5 dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_req     (req),
    .i_ack     (ack),
    .o_addr    (addr),
    .o_valid   (valid),
    .o_pending (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Round-robin pick: first pending line met when walking upward from ptr, wrapping at 32.
  function automatic int rr_pick(input logic [31:0] p, input int ptr);
    for (int k = 0; k < 32; k++) begin
      if (p[(ptr + k) % 32]) return (ptr + k) % 32;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_addr  = 0;
    m_ptr   = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
    chk({tag, ".addr"}, {27'd0, addr}, m_addr);
    chk({tag, ".pending"}, pending, m_pend);
  endtask

  // Apply req/ack for one edge, advance the model, then compare just after the edge.
  task automatic step(input logic [31:0] r, input logic a, input string tag);
    logic [31:0] old_pend;
    req = r;
    ack = a;
    @(posedge clk);
    old_pend = m_pend;
    if (m_valid && a) m_pend[m_addr] = 1'b0;
    m_pend = m_pend | r;
    if (!m_valid) begin
      if (old_pend != 0) begin
        m_addr  = rr_pick(old_pend, m_ptr);
        m_valid = 1'b1;
      end
    end else if (a) begin
      m_valid = 1'b0;
      m_ptr   = (m_addr + 1) % 32;
    end
    #1;
    check_model(tag);
    req = '0;
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int exp_q[$];
  int gi;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    ack   = 1'b0;
    model_reset();

    // Reset holds everything at zero even with requests toggling.
    for (int c = 0; c < 4; c++) begin
      req = (c % 2 == 0) ? 32'hFFFF_FFFF : 32'h0;
      ack = 1'b1;
      @(posedge clk);
      #1;
      chk("rst.valid", {31'd0, valid}, 32'd0);
      chk("rst.addr", {27'd0, addr}, 32'd0);
      chk("rst.pending", pending, 32'd0);
    end
    req = '0;
    ack = 1'b0;
    rst_n = 1'b1;

    // Single request on line 7.
    step(32'h0000_0080, 1'b0, "single.e0");
    chk("single.pend_e0", pending, 32'h80);
    step(32'h0, 1'b0, "single.e1");
    chk("single.addr_e1", {27'd0, addr}, 32'd7);
    chk("single.valid_e1", {31'd0, valid}, 32'd1);
    step(32'h0, 1'b0, "single.hold1");
    step(32'h0, 1'b0, "single.hold2");
    chk("single.addr_hold", {27'd0, addr}, 32'd7);
    step(32'h0, 1'b1, "single.ack");
    chk("single.valid_ack", {31'd0, valid}, 32'd0);
    chk("single.pend_ack", pending, 32'd0);

    // Wrap and order from a fresh pointer.
    do_reset();
    exp_q = '{0, 4, 31, 0, 4, 9, 2};
    gi = 0;
    step(32'h8000_0011, 1'b1, "wrap.load");
    for (int c = 0; c < 6; c++) begin
      step(32'h0, 1'b1, "wrap.run");
      if (valid) begin
        chk("wrap.order", {27'd0, addr}, exp_q[gi]);
        gi++;
      end
    end
    step(32'h0000_0011, 1'b1, "wrap.reload");
    for (int c = 0; c < 4; c++) begin
      step(32'h0, 1'b1, "wrap.run2");
      if (valid) begin
        chk("wrap.order2", {27'd0, addr}, exp_q[gi]);
        gi++;
      end
    end
    // Pointer now 5: lines 2 and 9 together must grant 9 first.
    step(32'h0000_0204, 1'b1, "rr.load");
    for (int c = 0; c < 4; c++) begin
      step(32'h0, 1'b1, "rr.run");
      if (valid) begin
        chk("rr.order", {27'd0, addr}, exp_q[gi]);
        gi++;
      end
    end
    chk("rr.count", gi, 7);

    // Ack and re-request of the same line on one edge.
    step(32'h0000_0080, 1'b0, "coll.load");
    step(32'h0, 1'b0, "coll.grant");
    chk("coll.addr", {27'd0, addr}, 32'd7);
    step(32'h0000_0080, 1'b1, "coll.hit");
    chk("coll.pend7", {31'd0, pending[7]}, 32'd1);
    chk("coll.valid", {31'd0, valid}, 32'd0);
    step(32'h0, 1'b0, "coll.regrant");
    chk("coll.readdr", {27'd0, addr}, 32'd7);
    chk("coll.revalid", {31'd0, valid}, 32'd1);
    step(32'h0, 1'b1, "coll.clear");

    // Asynchronous reset in the middle of a grant.
    do_reset();
    step(32'h1000_1000, 1'b0, "rmid.load");
    step(32'h0, 1'b0, "rmid.grant");
    chk("rmid.addr", {27'd0, addr}, 32'd12);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmid.valid_async", {31'd0, valid}, 32'd0);
    chk("rmid.addr_async", {27'd0, addr}, 32'd0);
    chk("rmid.pend_async", pending, 32'd0);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) step(32'h0, 1'b1, "rmid.quiet");

    // Randomized traffic with sparse requests and random acks.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] r;
      r = $urandom & $urandom & $urandom;
      if ($urandom_range(0, 3) == 0) r = '0;
      if ($urandom_range(0, 49) == 0) r = 32'hFFFF_FFFF;
      step(r, 1'($urandom_range(0, 1)), "rand");
    end

    // Drain with all lines pending: each line exactly once per 32 grants.
    do_reset();
    step(32'hFFFF_FFFF, 1'b1, "full.load");
    for (int c = 0; c < 64; c++) step(32'h0, 1'b1, "full.run");
    chk("full.drained", pending, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
